// File: rtl/logic_pipe_unit.sv
// -----------------------------------------------------------------------------
// logic_pipe_unit
//   Two-stage pipelined bitwise logic unit with a valid/ready handshake on
//   both sides. S1 registers the incoming operands. S2 computes one of eight
//   bitwise operations and registers the result together with an equality
//   flag and a zero flag. In accumulate mode, operand b is replaced by the
//   previous result.
//
//   Optional feature: define LOGIC_PIPE_UNIT_PARITY_EN to add out_parity,
//   which is the registered even parity (^) of out_data.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand transaction offered
//   in_ready   unit can accept a transaction this cycle (combinational)
//   in_a       operand a
//   in_b       operand b
//   in_op      operation select (see op_e)
//   in_acc     1 = use the accumulator in place of in_b
//   acc_clr    clear the accumulator (synchronous)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   result
//   out_eq     in_a == in_b for this transaction (raw in_b)
//   out_zero   out_data == 0
//   out_parity ^out_data (only with LOGIC_PIPE_UNIT_PARITY_EN)
// -----------------------------------------------------------------------------
module logic_pipe_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_eq,
    output logic             out_zero
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // S1 state
    logic             v1_q;
    logic [WIDTH-1:0] a1_q;
    logic [WIDTH-1:0] b1_q;
    op_e              op1_q;
    logic             acc1_q;

    // S2 state (drives the outputs directly)
    logic             v2_q;
    logic [WIDTH-1:0] data_q;
    logic             eq_q;
    logic             zero_q;

    logic [WIDTH-1:0] acc_q;

    logic             s1_adv;
    logic             s2_adv;
    logic             s2_cap;
    logic [WIDTH-1:0] acc_opnd;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] result_d;

    // A stage may advance when it is empty or its successor is moving.
    assign s2_adv   = !v2_q || out_ready;
    assign s1_adv   = !v1_q || s2_adv;
    assign s2_cap   = s2_adv && v1_q;
    assign in_ready = s1_adv;

    // A clear in the same cycle as a capture must apply to that capture's
    // operand. Otherwise, the captured result would still see the old value.
    assign acc_opnd = acc_clr ? '0 : acc_q;
    assign b_eff    = acc1_q ? acc_opnd : b1_q;

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        result_d = a1_q;
        unique case (op1_q)
            OP_AND:  result_d = a1_q & b_eff;
            OP_OR:   result_d = a1_q | b_eff;
            OP_XOR:  result_d = a1_q ^ b_eff;
            OP_XNOR: result_d = ~(a1_q ^ b_eff);
            OP_NAND: result_d = ~(a1_q & b_eff);
            OP_NOR:  result_d = ~(a1_q | b_eff);
            OP_NOTA: result_d = ~a1_q;
            OP_PASS: result_d = a1_q;
            default: result_d = a1_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            op1_q  <= OP_AND;
            acc1_q <= 1'b0;
        end else if (s1_adv) begin
            v1_q <= in_valid;
            // Payload is only loaded for real transactions, so idle inputs
            // never disturb the held fields.
            if (in_valid) begin
                a1_q   <= in_a;
                b1_q   <= in_b;
                op1_q  <= op_e'(in_op);
                acc1_q <= in_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            data_q <= '0;
            eq_q   <= 1'b0;
            zero_q <= 1'b0;
        end else if (s2_adv) begin
            v2_q <= v1_q;
            if (v1_q) begin
                data_q <= result_d;
                eq_q   <= &(~(a1_q ^ b1_q));
                zero_q <= ~|result_d;
            end
        end
    end

    // A capture always reloads the accumulator. This lets back-to-back
    // accumulate transactions chain without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (s2_cap) begin
            acc_q <= result_d;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

`ifdef LOGIC_PIPE_UNIT_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (s2_cap) begin
            parity_q <= ^result_d;
        end
    end

    assign out_parity = parity_q;
`endif

    assign out_valid = v2_q;
    assign out_data  = data_q;
    assign out_eq    = eq_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// -----------------------------------------------------------------------------
// tb_logic_pipe_unit
//   Self-checking bench for logic_pipe_unit (WIDTH=8). A transaction-level
//   model predicts each accepted transaction's result in order and keeps its
//   own accumulator. A negedge monitor compares every delivered result
//   against the prediction queue and checks that stalled outputs hold
//   steady. Directed sequences are followed by a randomized phase with
//   backpressure.
// -----------------------------------------------------------------------------
module tb_logic_pipe_unit;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         eq;
        logic         zero;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         in_acc;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_eq;
    logic         out_zero;
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
    logic         out_parity;
`endif

    logic_pipe_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_eq    (out_eq),
        .out_zero  (out_zero)
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_out   = 0;
    int           cyc     = 0;
    exp_t         sb[$];
    logic [W-1:0] model_acc = '0;
    bit           lat_chk = 0;
    bit           rnd_bp  = 0;
    bit           hold_valid = 0;
    logic [W-1:0] hold_data;
    logic         hold_eq;
    logic         hold_zero;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bitwise operation table, evaluated on whole operands.
    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a ^ b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Output monitor: delivered results, in order, plus stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 0;
        end else begin
            if (hold_valid) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data",  {24'd0, out_data}, {24'd0, hold_data});
                check("stall_flags", {30'd0, out_eq, out_zero}, {30'd0, hold_eq, hold_zero});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_out", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, e.data});
                    check("out_eq",   {31'd0, out_eq},   {31'd0, e.eq});
                    check("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
                    check("out_parity", {31'd0, out_parity}, {31'd0, ^e.data});
`endif
                    if (lat_chk) check("latency", cyc - e.cyc, 32'd2);
                end
            end
            hold_valid = out_valid && !out_ready;
            hold_data  = out_data;
            hold_eq    = out_eq;
            hold_zero  = out_zero;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_op    = 3'($urandom);
            in_acc   = 1'($urandom);
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
    endtask

    // Offer one transaction and wait (bounded) until it is accepted. clr
    // asserts acc_clr in the cycle this transaction is captured into S2; the
    // caller keeps out_ready=1 so that the capture happens in that cycle.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic acc, input logic clr, input bit use_exp,
                        input logic [W-1:0] exp_d);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W-1:0] r;
        int           n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_acc   = acc;
        n        = 0;
        forever begin
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                step();
                return;
            end
            step();
        end
        bb        = acc ? (clr ? '0 : model_acc) : b;
        r         = ref_op(op, a, bb);
        model_acc = r;
        e.data    = use_exp ? exp_d : r;
        e.eq      = (a == b);
        e.zero    = (e.data == '0);
        e.cyc     = cyc;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
        in_acc   = 1'b0;
        if (clr) begin
            acc_clr = 1'b1;
            step();
            acc_clr = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic clr_pulse();
        acc_clr = 1'b1;
        step();
        acc_clr   = 1'b0;
        model_acc = '0;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        repeat (n) step();
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        model_acc = '0;
    endtask

    logic [W-1:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h5A, 8'hA5};

    initial begin
        int out_base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_acc    = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        step();

        // Reset held with in_valid=1: nothing may leak out afterwards.
        do_reset(2);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        check("rst_out_flags", {30'd0, out_eq, out_zero}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        step();
        @(negedge clk);
        check("rst_no_leak", {31'd0, out_valid}, 32'd0);
        step();
        // Accumulator starts at 0: OR with the accumulator and a=0 gives 0.
        send(8'h00, 8'h5A, 3'b001, 1'b1, 1'b0, 1, 8'h00);
        drain();

        // XNOR and equality flag.
        send(8'hF0, 8'hCC, 3'b011, 1'b0, 1'b0, 1, 8'hC3);
        send(8'h3C, 8'h3C, 3'b011, 1'b0, 1'b0, 1, 8'hFF);
        drain();

        // Op sweep back-to-back, 2-cycle latency each.
        lat_chk = 1;
        for (int i = 0; i < 8; i++) send(8'hA5, 8'h0F, 3'(i), 1'b0, 1'b0, 1, sweep_exp[i]);
        drain();
        lat_chk = 0;

        // Backpressure: two accepts fill the pipe, the third must wait.
        out_base  = n_out;
        out_ready = 1'b0;
        send(8'h11, 8'h00, 3'b111, 1'b0, 1'b0, 1, 8'h11);
        send(8'h22, 8'h00, 3'b111, 1'b0, 1'b0, 1, 8'h22);
        in_valid = 1'b1;
        in_a     = 8'h33;
        in_op    = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_head",     {24'd0, out_data}, 32'h11);
            step();
        end
        out_ready = 1'b1;
        send(8'h33, 8'h00, 3'b111, 1'b0, 1'b0, 1, 8'h33);
        drain();
        check("bp_count", n_out - out_base, 32'd3);

        // Accumulate chain, then a clear coincident with a capture.
        clr_pulse();
        send(8'h01, 8'h77, 3'b010, 1'b1, 1'b0, 1, 8'h01);
        send(8'h02, 8'h77, 3'b010, 1'b1, 1'b0, 1, 8'h03);
        send(8'h04, 8'h77, 3'b010, 1'b1, 1'b0, 1, 8'h07);
        send(8'h08, 8'h77, 3'b010, 1'b1, 1'b1, 1, 8'h08);
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(8'h5A, 8'h00, 3'b111, 1'b0, 1'b0, 1, 8'h5A);
        send(8'h6B, 8'h00, 3'b111, 1'b0, 1'b0, 1, 8'h6B);
        @(negedge clk);
        check("mid_full_valid", {31'd0, out_valid}, 32'd1);
        check("mid_full_ready", {31'd0, in_ready},  32'd0);
        step();
        do_reset(1);
        @(negedge clk);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready},  32'd1);
        step();
        out_ready = 1'b1;
        send(8'h10, 8'h3E, 3'b010, 1'b1, 1'b0, 1, 8'h10);
        drain();

        // Randomized traffic with backpressure and idle gaps.
        rnd_bp = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                drain();
                clr_pulse();
            end
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
            send(W'($urandom), ($urandom_range(0, 7) == 0) ? in_a : W'($urandom),
                 3'($urandom), ($urandom_range(0, 2) == 0), 1'b0, 0, '0);
        end
        rnd_bp = 0;
        drain();
        idle(3);
        check("final_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_pipe_unit.md
Name: logic_pipe_unit

Overview:
- Parametrised, pipelined successor to the single-function gate cells. Provides eight selectable bitwise operations over WIDTH-bit operands, with a valid/ready handshake.
- Adds an equality flag (XNOR reduction), a zero flag, and an accumulate mode. In accumulate mode the previous result replaces operand b.
- Sits between operand producers and result consumers in the datapath test fabric.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand transaction offered
in_ready  output  1  unit can accept transaction this cycle
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_op  input  3  operation select
in_acc  input  1  1 = use accumulator as operand b
acc_clr  input  1  clear accumulator
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result
out_eq  output  1  in_a == in_b of this transaction
out_zero  output  1  out_data == 0

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: stage valids=0, out_valid=0, out_data=0, out_eq=0, out_zero=0, accumulator=0. in_ready=1 in the first cycle after reset. Reset asserted mid-operation discards all in-flight transactions.
- Pipeline: stage S1 registers {a,b,op,acc}; stage S2 computes the result and registers the outputs. Latency is 2 cycles from in accept to out_valid when never stalled. Throughput is 1 per cycle.
- Advance rules: s2_adv = !v2 | out_ready; s1_adv = !v1 | s2_adv; in_ready = s1_adv (combinational).
- Transfers: in fire = in_valid & in_ready; out fire = out_valid & out_ready.
- Stalled stages hold all fields stable. There is no loss and no duplication; order is preserved.
- in_a/in_b/in_op are don't-care when in_valid=0.
- Op encoding (b' = acc if in_acc else b):
  - 000 a&b'
  - 001 a|b'
  - 010 a^b'
  - 011 ~(a^b')
  - 100 ~(a&b')
  - 101 ~(a|b')
  - 110 ~a
  - 111 a
- out_eq = &(~(a^b)) on raw in_b, regardless of in_acc. out_zero = ~|result.
- Accumulator: loads the result on every S2 capture, whatever in_acc is.
- acc_clr (synchronous): the accumulator becomes 0.
  - If an S2 capture coincides with acc_clr, the operand acc is treated as 0.
  - In that case the accumulator then loads that capture's result.
- Back-to-back acc transactions use the immediately preceding result, with no bubble.
- Width rules: all operations are bitwise at WIDTH; no carries, no extension.

Optional Feature:
- Macro LOGIC_PIPE_UNIT_PARITY_EN.
- Defined: adds port out_parity (output, 1) = ^out_data. It is registered with S2, resets to 0, and is held during stall.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0x00, in_ready=1 after release, accumulator=0.
- XNOR, WIDTH=8: a=0xF0, b=0xCC, op=011, out_ready=1 -> 2 cycles later out_data=0xC3, out_eq=0, out_zero=0. Then a=b=0x3C, op=011 -> out_data=0xFF, out_eq=1.
- Op sweep with a=0xA5, b=0x0F, op 000..111 back-to-back -> results 0x05, 0xAF, 0xAA, 0x55, 0xFA, 0x50, 0x5A, 0xA5 on consecutive cycles.
- Backpressure: out_ready=0 with in_valid held and data 0x11, 0x22, 0x33 -> in_ready=0 after 2 accepts. Then out_ready=1 -> outputs in order, 0x33 accepted, no duplicates.
- Accumulate: pulse acc_clr, then XOR with in_acc=1 and a=0x01, 0x02, 0x04 back-to-back -> 0x01, 0x03, 0x07. Then acc_clr coincident with a=0x08 capture -> 0x08.
- Reset mid-flight: both stages valid, out_ready=0, assert rst 1 cycle -> out_valid=0 next cycle. A following acc XOR with a=0x10 yields 0x10.
